// File: rtl/gpu_dcr_pkg.sv
// Shared definitions for the miniGPU device control register bank:
// register indices, CTRL/STATUS bit positions and the launch FSM state type.
package gpu_dcr_pkg;

    localparam int REG_THREAD_COUNT = 0;
    localparam int REG_PROG_BASE    = 1;
    localparam int REG_DATA_BASE    = 2;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_CLR_ERR  = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/dcr_launch_fsm.sv
// Kernel launch tracker: IDLE -> LAUNCH (one-cycle kernel_start) -> RUN until
// kernel_done. Also keeps the sticky done flag reported in STATUS.
module dcr_launch_fsm
    import gpu_dcr_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic launch,
    input  logic clr_done,
    input  logic kernel_done,
    output logic kernel_start,
    output logic busy,
    output logic done
);

    state_t state_reg, state_next;
    logic   done_reg, done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = done_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = LAUNCH;
            LAUNCH:  state_next = RUN;
            RUN:     if (kernel_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (launch || clr_done)
            done_next = 1'b0;
        // Completion is applied last so it beats a same-cycle CLR_DONE.
        if (state_reg == RUN && kernel_done)
            done_next = 1'b1;
    end

    // Decoded straight from the state register so both drop with the async reset.
    assign kernel_start = (state_reg == LAUNCH);
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;

endmodule

// File: rtl/dcr_bank.sv
// Host-visible device control registers for miniGPU: config registers feeding the
// Dispatcher plus a CTRL/STATUS register at the top index that launches kernels.
module dcr_bank
    import gpu_dcr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic [DATA_WIDTH-1:0]            thread_count,
    output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] cfg_flat,
    output logic                             kernel_start,
    input  logic                             kernel_done,
    output logic                             busy,
    output logic                             wr_err
);

    localparam int NUM_CFG  = NUM_REGS - 1;
    localparam int CTRL_IDX = NUM_REGS - 1;

    logic [DATA_WIDTH-1:0] cfg_regs [NUM_CFG];
    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] rd_data_reg, rd_data_next;
    logic                  rd_valid_reg;
    logic                  wr_err_reg;
    logic [31:0]           wr_idx, rd_idx;
    logic                  cfg_we, launch, clr_done, clr_err, err_set, done;

    assign wr_idx = 32'(wr_addr);
    assign rd_idx = 32'(rd_addr);

    always_comb begin
        cfg_we   = 1'b0;
        launch   = 1'b0;
        clr_done = 1'b0;
        clr_err  = 1'b0;
        err_set  = 1'b0;
        if (wr_en) begin
            if (wr_idx < 32'(NUM_CFG)) begin
                if (busy) err_set = 1'b1;
                else      cfg_we  = 1'b1;
            end else if (wr_idx == 32'(CTRL_IDX)) begin
                clr_done = wr_data[CTRL_CLR_DONE];
                clr_err  = wr_data[CTRL_CLR_ERR];
                if (wr_data[CTRL_START]) begin
                    if (busy || thread_count == '0) err_set = 1'b1;
                    else                            launch  = 1'b1;
                end
            end else begin
                err_set = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    cfg_regs[gi] <= '0;
                else if (cfg_we && wr_idx == 32'(gi))
                    cfg_regs[gi] <= wr_data;
            end
            assign cfg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = cfg_regs[gi];
        end
    endgenerate

    assign thread_count = cfg_regs[REG_THREAD_COUNT];

    // Setting an error takes priority over a same-cycle CLR_ERR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     wr_err_reg <= 1'b0;
        else if (err_set) wr_err_reg <= 1'b1;
        else if (clr_err) wr_err_reg <= 1'b0;
    end

    assign wr_err = wr_err_reg;

    dcr_launch_fsm u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .launch       (launch),
        .clr_done     (clr_done),
        .kernel_done  (kernel_done),
        .kernel_start (kernel_start),
        .busy         (busy),
        .done         (done)
    );

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_DONE] = done;
        status[STAT_ERR]  = wr_err_reg;
    end

    always_comb begin
        rd_data_next = '0;
        for (int i = 0; i < NUM_CFG; i++)
            if (rd_idx == 32'(i)) rd_data_next = cfg_regs[i];
        if (rd_idx == 32'(CTRL_IDX))
            rd_data_next = status;
    end

    // Reads sample pre-edge state, so a same-cycle write returns the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) rd_data_reg <= rd_data_next;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_dcr_bank.sv
// Directed bench for dcr_bank: default 8-bit/4-register instance plus a
// 16-bit/8-register instance for the wide-parameter case.
module tb_dcr_bank;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        wr_en = 1'b0, rd_en = 1'b0, kernel_done = 1'b0;
    logic [2:0]  wr_addr = '0, rd_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  rd_data, thread_count;
    logic [23:0] cfg_flat;
    logic        rd_valid, kernel_start, busy, wr_err;

    logic         b_wr_en = 1'b0, b_rd_en = 1'b0, b_kernel_done = 1'b0;
    logic [2:0]   b_wr_addr = '0, b_rd_addr = '0;
    logic [15:0]  b_wr_data = '0;
    logic [15:0]  b_rd_data, b_thread_count;
    logic [111:0] b_cfg_flat;
    logic         b_rd_valid, b_kernel_start, b_busy, b_wr_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcr_bank u_dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .thread_count(thread_count), .cfg_flat(cfg_flat),
        .kernel_start(kernel_start), .kernel_done(kernel_done),
        .busy(busy), .wr_err(wr_err)
    );

    dcr_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_REGS(8)) u_dut_wide (
        .clk(clk), .reset_n(reset_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .thread_count(b_thread_count), .cfg_flat(b_cfg_flat),
        .kernel_start(b_kernel_start), .kernel_done(b_kernel_done),
        .busy(b_busy), .wr_err(b_wr_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read(input logic [2:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic write_b(input logic [2:0] a, input logic [15:0] d);
        b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d;
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic read_b(input logic [2:0] a);
        b_rd_en = 1'b1; b_rd_addr = a;
        tick();
        b_rd_en = 1'b0;
    endtask

    task automatic pulse_done();
        kernel_done = 1'b1;
        tick();
        kernel_done = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_eq("rst_thread_count", 32'(thread_count), 32'h0);
        check_eq("rst_cfg_flat", 32'(cfg_flat), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_kstart", 32'(kernel_start), 32'h0);
        check_eq("rst_wr_err", 32'(wr_err), 32'h0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
        reset_n = 1'b1;
        tick();

        // 1: config write and readback latency
        write(3'd0, 8'd16);
        check_eq("t1_thread_count", 32'(thread_count), 32'd16);
        rd_en = 1'b1; rd_addr = 3'd0;
        check_eq("t1_rd_valid_pre", 32'(rd_valid), 32'h0);
        tick();
        rd_en = 1'b0;
        check_eq("t1_rd_data", 32'(rd_data), 32'd16);
        check_eq("t1_rd_valid", 32'(rd_valid), 32'h1);
        tick();
        check_eq("t1_rd_valid_drop", 32'(rd_valid), 32'h0);
        write(3'd1, 8'h12);
        write(3'd2, 8'h34);
        check_eq("t1_cfg_flat", 32'(cfg_flat), 32'h341210);
        // Same-cycle read and write of one address returns the old value
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h99;
        rd_en = 1'b1; rd_addr = 3'd1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_eq("t1_rw_old", 32'(rd_data), 32'h12);
        check_eq("t1_rw_new", 32'(cfg_flat[15:8]), 32'h99);

        // 2: launch and completion
        write(3'd3, 8'h01);
        check_eq("t2_kstart_launch", 32'(kernel_start), 32'h1);
        check_eq("t2_busy_launch", 32'(busy), 32'h1);
        tick();
        check_eq("t2_kstart_run", 32'(kernel_start), 32'h0);
        check_eq("t2_busy_run", 32'(busy), 32'h1);
        tick();
        check_eq("t2_busy_wait", 32'(busy), 32'h1);
        pulse_done();
        check_eq("t2_busy_done", 32'(busy), 32'h0);
        read(3'd3);
        check_eq("t2_status", 32'(rd_data), 32'h02);

        // 3: locking and errors while busy
        write(3'd3, 8'h01);
        tick();
        check_eq("t3_busy", 32'(busy), 32'h1);
        write(3'd0, 8'd5);
        check_eq("t3_cfg_locked", 32'(thread_count), 32'd16);
        check_eq("t3_err_cfg", 32'(wr_err), 32'h1);
        write(3'd3, 8'h04);
        check_eq("t3_err_clr", 32'(wr_err), 32'h0);
        write(3'd3, 8'h01);
        check_eq("t3_no_restart", 32'(kernel_start), 32'h0);
        check_eq("t3_err_start", 32'(wr_err), 32'h1);
        read(3'd3);
        check_eq("t3_status", 32'(rd_data), 32'h05);
        write(3'd3, 8'h05);
        check_eq("t3_err_wins", 32'(wr_err), 32'h1);
        write(3'd3, 8'h04);
        check_eq("t3_err_clr2", 32'(wr_err), 32'h0);
        // kernel_done together with CLR_DONE: done stays set
        kernel_done = 1'b1;
        write(3'd3, 8'h02);
        kernel_done = 1'b0;
        check_eq("t3_busy_end", 32'(busy), 32'h0);
        read(3'd3);
        check_eq("t3_done_wins", 32'(rd_data), 32'h02);
        write(3'd3, 8'h02);
        read(3'd3);
        check_eq("t3_done_clr", 32'(rd_data), 32'h00);

        // 4: zero thread count and out-of-range address
        write(3'd0, 8'd0);
        write(3'd3, 8'h01);
        check_eq("t4_no_kstart", 32'(kernel_start), 32'h0);
        check_eq("t4_not_busy", 32'(busy), 32'h0);
        check_eq("t4_err_zero", 32'(wr_err), 32'h1);
        write(3'd3, 8'h04);
        write(3'd7, 8'hAA);
        check_eq("t4_err_oob", 32'(wr_err), 32'h1);
        check_eq("t4_cfg_keep", 32'(cfg_flat), 32'h349900);
        read(3'd7);
        check_eq("t4_rd_oob", 32'(rd_data), 32'h0);

        // 5: asynchronous reset during LAUNCH and RUN
        write(3'd0, 8'd16);
        write(3'd3, 8'h01);
        check_eq("t5_kstart_pre", 32'(kernel_start), 32'h1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_kstart_async", 32'(kernel_start), 32'h0);
        check_eq("t5_busy_async_l", 32'(busy), 32'h0);
        tick();
        reset_n = 1'b1;
        write(3'd0, 8'd16);
        write(3'd3, 8'h01);
        tick();
        check_eq("t5_busy_run", 32'(busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t5_busy_async_r", 32'(busy), 32'h0);
        check_eq("t5_kstart_run", 32'(kernel_start), 32'h0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read(3'(i));
            check_eq($sformatf("t5_reg%0d_zero", i), 32'(rd_data), 32'h0);
        end

        // 6: wide instance
        write_b(3'd6, 16'hBEEF);
        check_eq("t6_cfg_flat_hi", 32'(b_cfg_flat[111:96]), 32'hBEEF);
        check_eq("t6_cfg_flat_lo", 32'(b_cfg_flat[95:0] == '0), 32'h1);
        read_b(3'd6);
        check_eq("t6_rd_reg6", 32'(b_rd_data), 32'hBEEF);
        read_b(3'd7);
        check_eq("t6_status", 32'(b_rd_data), 32'h0);
        write_b(3'd0, 16'd3);
        write_b(3'd7, 16'h0001);
        check_eq("t6_kstart", 32'(b_kernel_start), 32'h1);
        read_b(3'd7);
        check_eq("t6_status_busy", 32'(b_rd_data), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
